// File: rtl/mem_swap_ctrl.sv
// Swap sequencer for two equal-size single-port RAMs behind write muxes.
// Optional abort support is enabled with `define SWAP_ABORT_EN.
module mem_swap_ctrl #(
    parameter int addr_w_N    = 7,
    parameter int data_w_Bits = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [data_w_Bits-1:0] rdata_a,
    input  logic [data_w_Bits-1:0] rdata_b,
    output logic                   each,
    output logic                   w,
    output logic [addr_w_N-1:0]    addr,
    output logic [data_w_Bits-1:0] wdata_a,
    output logic [data_w_Bits-1:0] wdata_b,
    output logic                   busy,
    output logic                   done
`ifdef SWAP_ABORT_EN
    ,
    input  logic                   abort,
    output logic                   aborted
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [addr_w_N-1:0]     r_cnt;
    logic [data_w_Bits-1:0]  r_wda;
    logic [data_w_Bits-1:0]  r_wdb;
    logic                    w_last;

    assign w_last = (r_cnt == {addr_w_N{1'b1}});

`ifdef SWAP_ABORT_EN
    logic w_abort_go;
    logic r_aborted;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode; the last-address compare stops the walk
    always_comb begin
        w_next = r_state;
`ifdef SWAP_ABORT_EN
        w_abort_go = 1'b0;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (start) w_next = S_READ;
            end
            S_READ: begin
                w_next = S_CAPT;
`ifdef SWAP_ABORT_EN
                if (abort) begin
                    w_next     = S_IDLE;
                    w_abort_go = 1'b1;
                end
`endif
            end
            S_CAPT: begin
                w_next = S_WRITE;
`ifdef SWAP_ABORT_EN
                if (abort) begin
                    w_next     = S_IDLE;
                    w_abort_go = 1'b1;
                end
`endif
            end
            S_WRITE: begin
                w_next = w_last ? S_DONE : S_READ;
`ifdef SWAP_ABORT_EN
                if (abort) begin
                    w_next     = S_IDLE;
                    w_abort_go = 1'b1;
                end
`endif
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Address counter: cleared on start, advanced after each write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_cnt <= '0;
        end else if (r_state == S_WRITE && w_next == S_READ) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Cross-over capture of the words read one cycle earlier
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wda <= '0;
            r_wdb <= '0;
        end else if (r_state == S_CAPT) begin
            r_wda <= rdata_b;
            r_wdb <= rdata_a;
        end
    end

`ifdef SWAP_ABORT_EN
    // One-cycle pulse on the return to idle after an abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_aborted <= 1'b0;
        else        r_aborted <= w_abort_go;
    end

    assign aborted = r_aborted;
`endif

    assign busy    = (r_state == S_READ) || (r_state == S_CAPT) ||
                     (r_state == S_WRITE);
    assign each    = busy;
    assign w       = (r_state == S_WRITE);
    assign done    = (r_state == S_DONE);
    assign addr    = r_cnt;
    assign wdata_a = r_wda;
    assign wdata_b = r_wdb;

endmodule

// File: tb/tb_mem_swap_ctrl.sv
// Directed bench for mem_swap_ctrl with two 8-word RAMs and write muxes.
// Abort steps run only when SWAP_ABORT_EN is defined.
module tb_mem_swap_ctrl;

    localparam int AW = 3;
    localparam int DW = 8;
    localparam int NW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] rdata_a, rdata_b;
    logic          each, w, busy, done;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata_a, wdata_b;
`ifdef SWAP_ABORT_EN
    logic          abort;
    logic          aborted;
`endif

    logic          u_we;
    logic [AW-1:0] u_addr;
    logic [DW-1:0] u_data;

    logic [DW-1:0] mem_a [NW];
    logic [DW-1:0] mem_b [NW];

    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_da, m_db;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_swap_ctrl #(.addr_w_N(AW), .data_w_Bits(DW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b),
        .each    (each),
        .w       (w),
        .addr    (addr),
        .wdata_a (wdata_a),
        .wdata_b (wdata_b),
        .busy    (busy),
        .done    (done)
`ifdef SWAP_ABORT_EN
        ,
        .abort   (abort),
        .aborted (aborted)
`endif
    );

    // Write muxes in front of the RAMs
    assign m_we   = each ? w : u_we;
    assign m_addr = each ? addr : u_addr;
    assign m_da   = each ? wdata_a : u_data;
    assign m_db   = each ? wdata_b : u_data;

    // Single-port RAMs with one-cycle read latency
    always @(posedge clk) begin
        if (m_we) begin
            mem_a[m_addr] <= m_da;
            mem_b[m_addr] <= m_db;
        end
        rdata_a <= mem_a[m_addr];
        rdata_b <= mem_b[m_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic init_mem();
        for (int i = 0; i < NW; i++) begin
            mem_a[i] = DW'(i);
            mem_b[i] = DW'(8'h80 + i);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        u_we   = 1'b0;
        u_addr = '0;
        u_data = '0;
`ifdef SWAP_ABORT_EN
        abort  = 1'b0;
`endif
        init_mem();
        step();
        step();

        chk("rst_each", 32'(each), 32'd0);
        chk("rst_w", 32'(w), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_wda", 32'(wdata_a), 32'd0);
        chk("rst_wdb", 32'(wdata_b), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
`ifdef SWAP_ABORT_EN
        chk("rst_aborted", 32'(aborted), 32'd0);
`endif

        rst_n = 1'b1;
        step();
        chk("idle_busy", 32'(busy), 32'd0);

        // Full swap, with a stray start toggle mid-way
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 24; c++) begin
            chk($sformatf("busy_c%0d", c), 32'(busy), 32'd1);
            chk($sformatf("each_c%0d", c), 32'(each), 32'd1);
            chk($sformatf("w_c%0d", c), 32'(w), 32'((c % 3) == 2));
            chk($sformatf("addr_c%0d", c), 32'(addr), 32'(c / 3));
            chk($sformatf("done_c%0d", c), 32'(done), 32'd0);
            start = (c == 7);
            step();
        end
        start = 1'b0;
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_each", 32'(each), 32'd0);
        step();
        chk("post_done", 32'(done), 32'd0);
        chk("post_busy", 32'(busy), 32'd0);
        for (int i = 0; i < NW; i++) begin
            chk($sformatf("swapA%0d", i), 32'(mem_a[i]), 32'(8'h80 + i));
            chk($sformatf("swapB%0d", i), 32'(mem_b[i]), 32'(i));
        end
        chk("hold_wda", 32'(wdata_a), 32'h87);
        chk("hold_wdb", 32'(wdata_b), 32'h07);

        // User write through the released muxes
        u_we   = 1'b1;
        u_addr = 3'd3;
        u_data = 8'h5A;
        step();
        u_we = 1'b0;
        step();
        chk("user_A3", 32'(mem_a[3]), 32'h5A);
        chk("user_wda", 32'(wdata_a), 32'h87);
        chk("user_wdb", 32'(wdata_b), 32'h07);

        // start held high: one idle cycle between swaps
        init_mem();
        start = 1'b1;
        step();
        for (int c = 0; c < 24; c++) step();
        chk("held_done", 32'(done), 32'd1);
        step();
        chk("held_gap_busy", 32'(busy), 32'd0);
        chk("held_gap_each", 32'(each), 32'd0);
        step();
        chk("held_restart", 32'(busy), 32'd1);
        chk("held_addr0", 32'(addr), 32'd0);
        start = 1'b0;

        // Reset while address 4 is in CAPTURE
        for (int c = 0; c < 13; c++) step();
        chk("pre_rst_addr", 32'(addr), 32'd4);
        chk("pre_rst_w", 32'(w), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_each", 32'(each), 32'd0);
        chk("mid_rst_addr", 32'(addr), 32'd0);
        chk("mid_rst_wda", 32'(wdata_a), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < NW; i++) begin
            chk($sformatf("rstA%0d", i), 32'(mem_a[i]),
                (i < 4) ? 32'(i) : 32'(8'h80 + i));
            chk($sformatf("rstB%0d", i), 32'(mem_b[i]),
                (i < 4) ? 32'(8'h80 + i) : 32'(i));
        end

`ifdef SWAP_ABORT_EN
        // Abort in WRITE of address 2
        init_mem();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 8; c++) step();
        chk("abw_w", 32'(w), 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abw_aborted", 32'(aborted), 32'd1);
        chk("abw_busy", 32'(busy), 32'd0);
        chk("abw_done", 32'(done), 32'd0);
        step();
        chk("abw_pulse_end", 32'(aborted), 32'd0);
        chk("abw_done2", 32'(done), 32'd0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("abwA%0d", i), 32'(mem_a[i]),
                (i < 3) ? 32'(8'h80 + i) : 32'(i));

        // Abort in READ of address 5
        init_mem();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 15; c++) step();
        chk("abr_addr", 32'(addr), 32'd5);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abr_aborted", 32'(aborted), 32'd1);
        chk("abr_busy", 32'(busy), 32'd0);
        step();
        chk("abr_A4", 32'(mem_a[4]), 32'h84);
        chk("abr_A5", 32'(mem_a[5]), 32'h05);
        chk("abr_B5", 32'(mem_b[5]), 32'h85);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
